// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_e  : arbiter FSM states (IDLE, ISSUE, RESP)
//   F3_*         : RISC-V load/store funct3 size/sign codes (forwarded untouched)
//   PORT_*       : requester port indices (0 = CPU, 1 = debug/DMA)
//   CNT_W        : width of the fixed-priority starvation counter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_DBG  = 1;

    localparam int unsigned CNT_W = 8;

    // Loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner selection for the two-port arbiter.
// Configuration macro: DMEM_ARB_RR_EN
//   defined   -> round-robin; rr_ptr names the port that wins a tie.
//   undefined -> port 0 wins ties unless port 1 has been passed over
//                STARVE_MAX times in a row (starve_cnt).
// Ports:
//   req        in  [1:0]        per-port request
//   rr_ptr     in  1            tie winner (round-robin build only)
//   starve_cnt in  [CNT_W-1:0]  consecutive port-0 wins with port 1 waiting (fixed build)
//   win        out [1:0]        one-hot winner, zero when no request
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic [1:0]       req,
`ifdef DMEM_ARB_RR_EN
    input  logic             rr_ptr,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic [1:0]       win
);

    // The starvation counter saturates at STARVE_MAX, so it must fit.
    if (STARVE_MAX > ((1 << CNT_W) - 1)) begin : g_bad_starve_max
        $error("STARVE_MAX does not fit the starvation counter");
    end

    always_comb begin
        win = req;
        if (req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            win = rr_ptr ? 2'b10 : 2'b01;
`else
            win = (starve_cnt >= CNT_W'(STARVE_MAX)) ? 2'b10 : 2'b01;
`endif
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Port 0 is the CPU, port 1 debug/DMA. A request is accepted in IDLE, issued
// to memory for one cycle (ISSUE, gnt pulse) and, for loads, returned one
// cycle later (RESP, rvalid pulse). Stores take 2 cycles, loads 3.
// Configuration macro: DMEM_ARB_RR_EN (round-robin); default is fixed
// priority to port 0 with starvation relief for port 1 after STARVE_MAX wins.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req/we [1:0]               per-port request and store flag
//   addr/wdata [63:0]          port i field in bits [32i+31:32i]
//   funct3 [5:0]               port i code in bits [3i+2:3i]
//   gnt/rvalid [1:0]           one-hot accept / load-data pulses
//   rdata [31:0]               load data, qualified by rvalid
//   busy                       FSM not in IDLE
//   mem_*                      data memory bus; mem_ReadData valid one
//                              cycle after mem_MemRead
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [5:0]  funct3,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [31:0] mem_WriteData,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_ReadData
);

    arb_state_e  r_state;
    arb_state_e  w_state_nxt;

    logic        r_port;     // port being served
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;

    logic [1:0]  w_win;
    logic        w_win_idx;
    logic        w_accept;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_funct3;

`ifdef DMEM_ARB_RR_EN
    logic        r_rr_ptr;   // port that wins the next tie

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .win    (w_win)
    );
`else
    logic [CNT_W-1:0] r_starve_cnt;

    dmem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .req        (req),
        .starve_cnt (r_starve_cnt),
        .win        (w_win)
    );
`endif

    assign w_win_idx    = w_win[PORT_DBG];
    assign w_accept     = (r_state == IDLE) && (w_win != 2'b00);
    assign w_sel_addr   = w_win_idx ? addr[63:32]   : addr[31:0];
    assign w_sel_wdata  = w_win_idx ? wdata[63:32]  : wdata[31:0];
    assign w_sel_funct3 = w_win_idx ? funct3[5:3]   : funct3[2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_port   <= w_win_idx;
                r_we     <= we[w_win_idx];
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
                r_funct3 <= w_sel_funct3;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_win_idx;
        end
    end
`else
    // Counts port-0 wins taken while port 1 was also asking; any IDLE cycle
    // without a port-1 request, or a port-1 win, ends the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (!req[PORT_DBG] || w_win[PORT_DBG]) begin
                r_starve_cnt <= '0;
            end else if (w_win[PORT_CPU] && (r_starve_cnt < CNT_W'(STARVE_MAX))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        gnt          = 2'b00;
        rvalid       = 2'b00;
        rdata        = '0;
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        busy         = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                gnt          = r_port ? 2'b10 : 2'b01;
                mem_MemRead  = ~r_we;
                mem_MemWrite = r_we;
                w_state_nxt  = r_we ? IDLE : RESP;
            end
            RESP: begin
                rvalid      = r_port ? 2'b10 : 2'b01;
                rdata       = mem_ReadData;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Memory bus fields hold the last accepted request between strobes.
    assign mem_addr      = r_addr;
    assign mem_WriteData = r_wdata;
    assign mem_funct3    = r_funct3;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Transaction-level reference: two requester queues, an arbitration policy
// computed from the tie-break rules, and a memory that returns a chosen word.
module tb_dmem_arbiter;

    localparam int unsigned STARVE = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [5:0]  funct3;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] mem_addr;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_WriteData;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_ReadData;

    dmem_arbiter #(
        .STARVE_MAX (STARVE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .funct3        (funct3),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .busy          (busy),
        .mem_addr      (mem_addr),
        .mem_MemRead   (mem_MemRead),
        .mem_MemWrite  (mem_MemWrite),
        .mem_WriteData (mem_WriteData),
        .mem_funct3    (mem_funct3),
        .mem_ReadData  (mem_ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Requester-side view of each port's outstanding access.
    bit          p_pend  [2];
    bit          p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [2:0]  p_f3    [2];

    // Arbitration policy state.
    int m_prio;   // port that wins a tie (round-robin build)
    int m_cnt;    // port-0 wins in a row while port 1 waits (fixed build)

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus();
        req    = {p_pend[1], p_pend[0]};
        we     = {p_we[1], p_we[0]};
        addr   = {p_addr[1], p_addr[0]};
        wdata  = {p_wdata[1], p_wdata[0]};
        funct3 = {p_f3[1], p_f3[0]};
    endtask

    task automatic post(input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f);
        p_pend[p]  = 1'b1;
        p_we[p]    = w;
        p_addr[p]  = a;
        p_wdata[p] = d;
        p_f3[p]    = f;
    endtask

    task automatic model_reset();
        m_prio = 0;
        m_cnt  = 0;
        for (int i = 0; i < 2; i++) p_pend[i] = 1'b0;
    endtask

    // Decide who is served from the pending requests seen in an IDLE cycle.
    task automatic model_pick(output int w);
        bit r0;
        bit r1;
        r0 = p_pend[0];
        r1 = p_pend[1];
        w  = -1;
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            w = m_prio;
`else
            w = (m_cnt >= STARVE) ? 1 : 0;
`endif
        end else if (r0) begin
            w = 0;
        end else if (r1) begin
            w = 1;
        end
`ifdef DMEM_ARB_RR_EN
        if (w >= 0) m_prio = 1 - w;
`else
        if (!r1 || w == 1) m_cnt = 0;
        else if (m_cnt < STARVE) m_cnt++;
`endif
    endtask

    // Entered at a falling edge while the arbiter should be idle; returns
    // at the falling edge of the next idle cycle.
    task automatic run_slot(input logic [31:0] rd, output int w);
        logic [1:0] g;
        chk("idle_busy", busy, 1'b0);
        chk("idle_gnt", gnt, 2'b00);
        chk("idle_rvalid", rvalid, 2'b00);
        chk("idle_strobes", {mem_MemRead, mem_MemWrite}, 2'b00);
        drive_bus();
        model_pick(w);
        @(negedge clk);
        if (w < 0) return;
        g = (w == 1) ? 2'b10 : 2'b01;
        chk("gnt", gnt, g);
        chk("issue_rvalid", rvalid, 2'b00);
        chk("issue_busy", busy, 1'b1);
        chk("mem_read", mem_MemRead, !p_we[w]);
        chk("mem_write", mem_MemWrite, p_we[w]);
        chk("mem_addr", mem_addr, p_addr[w]);
        chk("mem_wdata", mem_WriteData, p_wdata[w]);
        chk("mem_funct3", mem_funct3, p_f3[w]);
        mem_ReadData = rd;
        p_pend[w]    = 1'b0;
        drive_bus();
        @(negedge clk);
        if (!p_we[w]) begin
            chk("rvalid", rvalid, g);
            chk("rdata", rdata, rd);
            chk("resp_gnt", gnt, 2'b00);
            chk("resp_strobes", {mem_MemRead, mem_MemWrite}, 2'b00);
            chk("resp_busy", busy, 1'b1);
            @(negedge clk);
        end
        mem_ReadData = $urandom;
    endtask

    initial begin
        int w;
        int exp_w;
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        mem_ReadData = '0;
        for (int i = 0; i < 2; i++) begin
            p_we[i]    = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
            p_f3[i]    = '0;
        end
        model_reset();
        drive_bus();
        @(negedge clk);
        @(negedge clk);

        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {mem_MemRead, mem_MemWrite}, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_WriteData, 32'h0);
        chk("rst_mem_funct3", mem_funct3, 3'b000);
        reset = 1'b0;
        @(negedge clk);

        // Port-0 word load.
        post(0, 1'b0, 32'h0000_0010, 32'h0, 3'b010);
        run_slot(32'hDEAD_BEEF, w);
        chk("load_winner", w, 0);

        // Port-1 halfword store.
        post(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 3'b001);
        run_slot(32'h0, w);
        chk("store_winner", w, 1);

        // Reset landing in the RESP cycle of a port-0 load.
        post(0, 1'b0, 32'h0000_0044, 32'h0, 3'b010);
        drive_bus();
        model_pick(w);
        @(negedge clk);
        chk("abort_gnt", gnt, 2'b01);
        mem_ReadData = 32'hCAFE_F00D;
        p_pend[0]    = 1'b0;
        drive_bus();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_rvalid", rvalid, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_strobes", {mem_MemRead, mem_MemWrite}, 2'b00);
        chk("abort_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);

        // Both ports issuing back-to-back loads straight out of reset.
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_pend[p]) post(p, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
            end
            run_slot($urandom, w);
`ifdef DMEM_ARB_RR_EN
            exp_w = i % 2;
`else
            exp_w = ((i % (STARVE + 1)) == STARVE) ? 1 : 0;
`endif
            chk("contend_seq", w, exp_w);
        end

        // Random traffic: idle gaps, single and contended requests.
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_pend[p] && ($urandom_range(0, 3) != 0)) begin
                    post(p, 1'($urandom_range(0, 1)), $urandom, $urandom,
                         3'($urandom_range(0, 7)));
                end
            end
            run_slot($urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
